// File: rtl/match_if.sv
// Game-side signal bundle for match_ctrl: ball/paddle/button inputs and
// score/speed/status outputs. The controller uses the slave modport.
interface match_if #(
  parameter int SCORE_W = 4,
  parameter int SPEED_W = 5
);
  logic               start;
  logic               pause;
  logic               out_left;
  logic               out_right;
  logic               paddle_hit;
  logic [SPEED_W-1:0] speed;
  logic               serve_dir;
  logic               ball_reset;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic               game_over;
  logic               paused;

  modport master (
    output start, pause, out_left, out_right, paddle_hit,
    input  speed, serve_dir, ball_reset, score_p1, score_p2, game_over, paused
  );

  modport slave (
    input  start, pause, out_left, out_right, paddle_hit,
    output speed, serve_dir, ball_reset, score_p1, score_p2, game_over, paused
  );
endinterface

// File: rtl/match_ctrl.sv
// Match sequencer for a two-player ball game: serve freeze, rally speed-up,
// scoring and pause. All outputs come straight from flops.
//
// state    | meaning
// FREEZE   | ball held; freeze counter runs down to the next serve
// PLAY     | rally live; outs score, hits speed the ball up
// PAUSED   | rally suspended; speed parked in saved_speed
module match_ctrl #(
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 9,
  parameter int FREEZE_W      = 14,
  parameter int SERVE_FREEZE  = 2000,
  parameter int OVER_FREEZE   = 16383,
  parameter int SPEED_W       = 5,
  parameter int BASE_SPEED    = 11,
  parameter int MAX_SPEED     = 15,
  parameter int HITS_PER_STEP = 4
) (
  input  logic    game_clk,
  input  logic    reset,
  match_if.slave  bus
);
  localparam int HIT_W = $clog2(HITS_PER_STEP + 1);

  localparam logic [SCORE_W-1:0]  WIN_V   = SCORE_W'(WIN_SCORE);
  localparam logic [FREEZE_W-1:0] SERVE_V = FREEZE_W'(SERVE_FREEZE);
  localparam logic [FREEZE_W-1:0] OVER_V  = FREEZE_W'(OVER_FREEZE);
  localparam logic [SPEED_W-1:0]  BASE_V  = SPEED_W'(BASE_SPEED);
  localparam logic [SPEED_W-1:0]  MAX_V   = SPEED_W'(MAX_SPEED);
  localparam logic [HIT_W-1:0]    HITS_V  = HIT_W'(HITS_PER_STEP);

  typedef enum logic [1:0] {S_FREEZE, S_PLAY, S_PAUSED} state_t;

  state_t              state_q, state_d;
  logic [FREEZE_W-1:0] freeze_q, freeze_d;
  logic [SCORE_W-1:0]  score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [SPEED_W-1:0]  speed_q, speed_d, saved_speed_q, saved_speed_d;
  logic [HIT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic                serve_dir_q, serve_dir_d;
  logic                game_over_q, game_over_d;
  logic                paused_q, paused_d;
  logic                ball_reset_q, ball_reset_d;
  logic                pause_prev_q, pause_prev_d;

  logic               pause_rise;
  logic [SCORE_W-1:0] p1_inc, p2_inc, new_score;

  assign pause_rise = bus.pause & ~pause_prev_q;
  assign p1_inc     = (score_p1_q >= WIN_V) ? WIN_V : score_p1_q + 1'b1;
  assign p2_inc     = (score_p2_q >= WIN_V) ? WIN_V : score_p2_q + 1'b1;
  assign new_score  = bus.out_left ? p1_inc : p2_inc;

  always_comb begin
    state_d       = state_q;
    freeze_d      = freeze_q;
    score_p1_d    = score_p1_q;
    score_p2_d    = score_p2_q;
    speed_d       = speed_q;
    saved_speed_d = saved_speed_q;
    hit_cnt_d     = hit_cnt_q;
    serve_dir_d   = serve_dir_q;
    game_over_d   = game_over_q;
    paused_d      = paused_q;
    ball_reset_d  = 1'b0;
    pause_prev_d  = bus.pause;

    unique case (state_q)
      S_FREEZE: begin
        if (freeze_q == '0) begin
          state_d   = S_PLAY;
          speed_d   = BASE_V;
          hit_cnt_d = '0;
        end else begin
          freeze_d = bus.start ? FREEZE_W'(1) : freeze_q - 1'b1;
          // Centre the ball only on the real 1->0 step, so a start landing
          // on freeze==1 does not produce a second strobe.
          if (freeze_q == FREEZE_W'(1) && !bus.start) ball_reset_d = 1'b1;
          if (freeze_q == FREEZE_W'(1) && game_over_q) begin
            score_p1_d  = '0;
            score_p2_d  = '0;
            game_over_d = 1'b0;
          end
        end
      end

      S_PLAY: begin
        if (bus.out_left || bus.out_right) begin
          if (bus.out_left) begin
            score_p1_d  = p1_inc;
            serve_dir_d = 1'b0;
          end else begin
            score_p2_d  = p2_inc;
            serve_dir_d = 1'b1;
          end
          speed_d = '0;
          state_d = S_FREEZE;
          if (new_score == WIN_V) begin
            freeze_d    = OVER_V;
            game_over_d = 1'b1;
          end else begin
            freeze_d = SERVE_V;
          end
        end else if (pause_rise) begin
          saved_speed_d = speed_q;
          speed_d       = '0;
          paused_d      = 1'b1;
          state_d       = S_PAUSED;
        end else if (bus.paddle_hit) begin
          if (hit_cnt_q == HITS_V - 1'b1) begin
            hit_cnt_d = '0;
            speed_d   = (speed_q >= MAX_V) ? MAX_V : speed_q + 1'b1;
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end

      S_PAUSED: begin
        if (pause_rise) begin
          speed_d  = saved_speed_q;
          paused_d = 1'b0;
          state_d  = S_PLAY;
        end
      end

      default: state_d = S_FREEZE;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q       <= S_FREEZE;
      freeze_q      <= OVER_V;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      speed_q       <= '0;
      saved_speed_q <= '0;
      hit_cnt_q     <= '0;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      paused_q      <= 1'b0;
      ball_reset_q  <= 1'b1;
      pause_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      freeze_q      <= freeze_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      speed_q       <= speed_d;
      saved_speed_q <= saved_speed_d;
      hit_cnt_q     <= hit_cnt_d;
      serve_dir_q   <= serve_dir_d;
      game_over_q   <= game_over_d;
      paused_q      <= paused_d;
      ball_reset_q  <= ball_reset_d;
      pause_prev_q  <= pause_prev_d;
    end
  end

  assign bus.speed      = speed_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.score_p1   = score_p1_q;
  assign bus.score_p2   = score_p2_q;
  assign bus.game_over  = game_over_q;
  assign bus.paused     = paused_q;
endmodule
